evt_window_sched: RTL

Time-multiplexes one `evt_counter` instance across `NUM_CH` event sources. It gates each enabled channel into the counter for a fixed window of `WINDOW_CYCLES` clocks and latches the result. It presents `{channel, count, overflow}` on a valid/ready result port. Channels are visited round-robin, and the block sits between the per-channel event strobes and the reporting/UART logic.

---
 rtl/evt_sched_pkg.sv | 12 +
 rtl/evt_counter.sv | 26 ++
 rtl/evt_window_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/evt_sched_pkg.sv
// Shared types for the windowed event-counter scheduler.
package evt_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StLatch,
    StPresent
  } sched_state_t;

endpackage

// File: rtl/evt_counter.sv
// Modulo-MAX_COUNT event counter with a synchronous, active-high clear.
module evt_counter #(
  parameter int unsigned MAX_COUNT = 40_000,
  localparam int unsigned CntW = $clog2(MAX_COUNT)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            evt_in,
  output logic [CntW-1:0] count_out,
  output logic            at_max_out
);

  logic [CntW-1:0] count_q;

  assign at_max_out = (count_q == CntW'(MAX_COUNT - 1));
  assign count_out  = count_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else if (evt_in) begin
      count_q <= at_max_out ? '0 : count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/evt_window_sched.sv
// Round-robin scheduler sharing one evt_counter across NUM_CH event channels,
// counting each selected channel for a fixed window and presenting the result.
module evt_window_sched
  import evt_sched_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned WINDOW_CYCLES = 100_000,
  parameter int unsigned MAX_COUNT     = 40_000,
  localparam int unsigned ChW  = $clog2(NUM_CH),
  localparam int unsigned WinW = $clog2(WINDOW_CYCLES + 1),
  localparam int unsigned CntW = $clog2(MAX_COUNT)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              run_in,
  input  logic [NUM_CH-1:0] ch_en_in,
  input  logic [NUM_CH-1:0] evt_in,
  output logic              result_valid_out,
  input  logic              result_ready_in,
  output logic [ChW-1:0]    result_ch_out,
  output logic [CntW-1:0]   result_count_out,
  output logic              result_ovf_out,
  output logic              busy_out,
  output logic [ChW-1:0]    active_ch_out
);

  // First enabled channel strictly after 'last', wrapping; 'last' itself is checked last.
  function automatic logic [ChW-1:0] rr_next(input logic [ChW-1:0]    last,
                                             input logic [NUM_CH-1:0] en);
    logic [ChW-1:0] pick;
    logic           found;
    int unsigned    idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = (32'(last) + i) % NUM_CH;
      if (!found && en[idx[ChW-1:0]]) begin
        pick  = ChW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  sched_state_t    state_q, state_d;
  logic [ChW-1:0]  last_ch_q, active_ch_q, rr_base, sel_ch;
  logic [WinW-1:0] win_q;
  logic            ovf_q;
  logic [ChW-1:0]  res_ch_q;
  logic [CntW-1:0] res_count_q;
  logic            res_ovf_q;
  logic            start, accept, gated_evt, cnt_clr, at_max;
  logic [CntW-1:0] count;

  assign gated_evt = (state_q == StGate) && evt_in[active_ch_q];
  assign cnt_clr   = !rst_in || (state_q == StClear);

  always_comb begin
    start   = run_in && (|ch_en_in);
    accept  = (state_q == StPresent) && result_ready_in;
    // On PRESENT exit last_ch is being updated to active_ch in the same edge.
    rr_base = (state_q == StPresent) ? active_ch_q : last_ch_q;
    sel_ch  = rr_next(rr_base, ch_en_in);
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StClear;
      StClear:   state_d = StGate;
      StGate:    if (win_q == WinW'(WINDOW_CYCLES - 1)) state_d = StLatch;
      StLatch:   state_d = StPresent;
      StPresent: if (result_ready_in) state_d = start ? StClear : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      last_ch_q   <= ChW'(NUM_CH - 1);
      active_ch_q <= '0;
      win_q       <= '0;
      ovf_q       <= 1'b0;
      res_ch_q    <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StClear) active_ch_q <= sel_ch;
      if (accept) last_ch_q <= active_ch_q;
      if (state_q == StClear) begin
        win_q <= '0;
        ovf_q <= 1'b0;
      end else if (state_q == StGate) begin
        win_q <= win_q + WinW'(1);
        if (gated_evt && at_max) ovf_q <= 1'b1;
      end
      if (state_q == StLatch) begin
        res_ch_q    <= active_ch_q;
        res_count_q <= count;
        res_ovf_q   <= ovf_q;
      end
    end
  end

  evt_counter #(
    .MAX_COUNT(MAX_COUNT)
  ) u_counter (
    .clk_in    (clk_in),
    .rst_in    (cnt_clr),
    .evt_in    (gated_evt),
    .count_out (count),
    .at_max_out(at_max)
  );

  assign result_valid_out = (state_q == StPresent);
  assign busy_out         = (state_q != StIdle);
  assign active_ch_out    = active_ch_q;
  assign result_ch_out    = res_ch_q;
  assign result_count_out = res_count_q;
  assign result_ovf_out   = res_ovf_q;

endmodule
